// File: rtl/jtag_dap_seq.sv
// DAP transfer sequencer: splits one DP/AP request into IR/TFR/RDBUFF engine steps; IR cache under JTAG_SEQ_IRCACHE_EN.
// Latency: 1 cycle accept->jif_go and idle-return->next jif_go; req_go ignored while busy or while the engine is not idle.
module jtag_dap_seq #(
  parameter int unsigned MAX_RETRY = 8,
  parameter logic [3:0]  IR_DPACC  = 4'hA,
  parameter logic [3:0]  IR_APACC  = 4'hB,
  parameter logic [3:0]  IR_IDCODE = 4'hE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_go,
  input  logic [1:0]  req_kind,
  input  logic        req_rnw,
  input  logic        req_apndp,
  input  logic [1:0]  req_addr32,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_done,
  output logic [2:0]  resp_ack,
  output logic [31:0] resp_data,
  output logic [1:0]  jif_cmd,
  output logic [3:0]  jif_ir,
  output logic        jif_rnw,
  output logic        jif_apndp,
  output logic [1:0]  jif_addr32,
  output logic [31:0] jif_dwrite,
  output logic        jif_go,
  input  logic        jif_idle,
  input  logic [2:0]  jif_ack,
  input  logic [31:0] jif_dread
);

  typedef enum logic [3:0] {
    S_IDLE, S_IR_ISSUE, S_IR_WAIT, S_TFR_ISSUE, S_TFR_WAIT,
    S_RB_IR_ISSUE, S_RB_IR_WAIT, S_RB_ISSUE, S_RB_WAIT, S_DONE
  } state_t;

  localparam logic [1:0] CMD_IR      = 2'd0;
  localparam logic [1:0] CMD_TFR     = 2'd1;
  localparam logic [1:0] CMD_READID  = 2'd2;
  localparam logic [1:0] CMD_RESET   = 2'd3;
  localparam logic [1:0] KIND_READID = 2'd1;
  localparam logic [1:0] KIND_RESET  = 2'd2;
  localparam logic [2:0] ACK_OK      = 3'b010;
  localparam logic [2:0] ACK_WAIT    = 3'b001;
  localparam logic [7:0] RETRY_MAX   = 8'(MAX_RETRY);

  state_t      state, state_nxt;
  logic [1:0]  cur_kind;
  logic        cur_rnw;
  logic [7:0]  retries, retries_nxt;
  logic [1:0]  cmd_nxt;
  logic [3:0]  ir_nxt;
  logic        rnw_nxt, apndp_nxt;
  logic [1:0]  addr_nxt;
  logic [31:0] dwrite_nxt;
  logic [2:0]  ack_nxt;
  logic [31:0] data_nxt;
  logic        latch;
  logic        cache_set, cache_inv;
  logic [3:0]  cache_val;
  logic [3:0]  req_ir;
  logic        hit_req, hit_dp;

  assign req_ir = req_apndp ? IR_APACC : IR_DPACC;

`ifdef JTAG_SEQ_IRCACHE_EN
  logic [3:0] ir_cache;
  logic       ir_cache_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_cache     <= 4'h0;
      ir_cache_vld <= 1'b0;
    end else if (cache_set) begin
      ir_cache     <= cache_val;
      ir_cache_vld <= 1'b1;
    end else if (cache_inv) begin
      ir_cache_vld <= 1'b0;
    end
  end

  assign hit_req = ir_cache_vld && (ir_cache == req_ir);
  assign hit_dp  = ir_cache_vld && (ir_cache == IR_DPACC);
`else
  // No cache: every TFR and RDBUFF fetch is preceded by an IR scan.
  logic unused_cache;
  assign unused_cache = ^{cache_set, cache_inv, cache_val};
  assign hit_req = 1'b0;
  assign hit_dp  = 1'b0;
`endif

  assign busy      = (state != S_IDLE);
  assign resp_done = (state == S_DONE);
  assign jif_go    = (state == S_IR_ISSUE) || (state == S_TFR_ISSUE) ||
                     (state == S_RB_IR_ISSUE) || (state == S_RB_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_nxt     = jif_cmd;
    ir_nxt      = jif_ir;
    rnw_nxt     = jif_rnw;
    apndp_nxt   = jif_apndp;
    addr_nxt    = jif_addr32;
    dwrite_nxt  = jif_dwrite;
    ack_nxt     = resp_ack;
    data_nxt    = resp_data;
    retries_nxt = retries;
    latch       = 1'b0;
    cache_set   = 1'b0;
    cache_inv   = 1'b0;
    cache_val   = IR_DPACC;
    case (state)
      S_IDLE: begin
        // A reset may leave the engine mid-scan; wait for it before accepting.
        if (req_go && jif_idle) begin
          latch       = 1'b1;
          retries_nxt = 8'd0;
          rnw_nxt     = req_rnw;
          apndp_nxt   = req_apndp;
          addr_nxt    = req_addr32;
          dwrite_nxt  = req_wdata;
          state_nxt   = S_TFR_ISSUE;
          if (req_kind == KIND_READID) begin
            cmd_nxt = CMD_READID;
          end else if (req_kind == KIND_RESET) begin
            cmd_nxt = CMD_RESET;
          end else if (hit_req) begin
            cmd_nxt = CMD_TFR;
          end else begin
            cmd_nxt   = CMD_IR;
            ir_nxt    = req_ir;
            state_nxt = S_IR_ISSUE;
          end
        end
      end
      S_IR_ISSUE:    if (!jif_idle) state_nxt = S_IR_WAIT;
      S_TFR_ISSUE:   if (!jif_idle) state_nxt = S_TFR_WAIT;
      S_RB_IR_ISSUE: if (!jif_idle) state_nxt = S_RB_IR_WAIT;
      S_RB_ISSUE:    if (!jif_idle) state_nxt = S_RB_WAIT;
      S_IR_WAIT, S_RB_IR_WAIT: begin
        if (jif_idle) begin
          cache_set   = 1'b1;
          cache_val   = jif_ir;
          cmd_nxt     = CMD_TFR;
          retries_nxt = 8'd0;
          state_nxt   = (state == S_IR_WAIT) ? S_TFR_ISSUE : S_RB_ISSUE;
        end
      end
      S_TFR_WAIT: begin
        if (jif_idle) begin
          if (cur_kind == KIND_READID) begin
            data_nxt  = jif_dread;
            ack_nxt   = ACK_OK;
            state_nxt = S_DONE;
          end else if (cur_kind == KIND_RESET) begin
            cache_set = 1'b1;
            cache_val = IR_IDCODE;
            ack_nxt   = ACK_OK;
            state_nxt = S_DONE;
          end else if (jif_ack == ACK_OK) begin
            if (!cur_rnw) begin
              ack_nxt   = ACK_OK;
              state_nxt = S_DONE;
            end else begin
              // Posted read: result comes from a DP RDBUFF scan.
              retries_nxt = 8'd0;
              rnw_nxt     = 1'b1;
              apndp_nxt   = 1'b0;
              addr_nxt    = 2'b11;
              if (hit_dp) begin
                cmd_nxt   = CMD_TFR;
                state_nxt = S_RB_ISSUE;
              end else begin
                cmd_nxt   = CMD_IR;
                ir_nxt    = IR_DPACC;
                state_nxt = S_RB_IR_ISSUE;
              end
            end
          end else begin
            cache_inv = 1'b1;
            if ((jif_ack == ACK_WAIT) && (retries < RETRY_MAX)) begin
              retries_nxt = retries + 8'd1;
              state_nxt   = S_TFR_ISSUE;
            end else begin
              ack_nxt   = jif_ack;
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_RB_WAIT: begin
        if (jif_idle) begin
          if (jif_ack == ACK_OK) begin
            data_nxt  = jif_dread;
            ack_nxt   = ACK_OK;
            state_nxt = S_DONE;
          end else begin
            cache_inv = 1'b1;
            if ((jif_ack == ACK_WAIT) && (retries < RETRY_MAX)) begin
              retries_nxt = retries + 8'd1;
              state_nxt   = S_RB_ISSUE;
            end else begin
              ack_nxt   = jif_ack;
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jif_cmd    <= CMD_RESET;
      jif_ir     <= 4'hF;
      jif_rnw    <= 1'b0;
      jif_apndp  <= 1'b0;
      jif_addr32 <= 2'b00;
      jif_dwrite <= 32'h0;
      resp_ack   <= 3'b000;
      resp_data  <= 32'h0;
      retries    <= 8'd0;
      cur_kind   <= 2'd0;
      cur_rnw    <= 1'b0;
    end else begin
      jif_cmd    <= cmd_nxt;
      jif_ir     <= ir_nxt;
      jif_rnw    <= rnw_nxt;
      jif_apndp  <= apndp_nxt;
      jif_addr32 <= addr_nxt;
      jif_dwrite <= dwrite_nxt;
      resp_ack   <= ack_nxt;
      resp_data  <= data_nxt;
      retries    <= retries_nxt;
      if (latch) begin
        cur_kind <= req_kind;
        cur_rnw  <= req_rnw;
      end
    end
  end

endmodule
